// File: rtl/tsip_packet_rx.sv
// TSIP receive engine: DLE/ETX deframing with DLE de-stuffing, ping-pong payload
// buffer with registered read port, and decode of the time packet into time fields.
module tsip_packet_rx #(
    parameter int         MAX_LEN      = 32,
    parameter int         TIMEOUT_CLKS = 20840,
    parameter logic [7:0] MATCH_ID     = 8'h8F,
    parameter logic [7:0] MATCH_SUB    = 8'hAB,
    parameter int         MATCH_LEN    = 17,
    parameter int         SEC_IDX      = 10
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_rx_dv,
    input  logic [7:0]                   i_rx_byte,
    input  logic [$clog2(MAX_LEN)-1:0]   i_rd_addr,
    output logic [7:0]                   o_rd_data,
    output logic                         o_pkt_dv,
    output logic [7:0]                   o_pkt_id,
    output logic [$clog2(MAX_LEN+1)-1:0] o_pkt_len,
    output logic                         o_err_frame,
    output logic                         o_err_ovf,
    output logic                         o_err_tmo,
    output logic                         o_busy,
    output logic                         o_time_dv,
    output logic [7:0]                   o_thunder_year_h,
    output logic [7:0]                   o_thunder_year_l,
    output logic [7:0]                   o_thunder_month,
    output logic [7:0]                   o_thunder_day,
    output logic [7:0]                   o_thunder_hour,
    output logic [7:0]                   o_thunder_minutes,
    output logic [7:0]                   o_thunder_seconds
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]    DLE       = 8'h10;
    localparam logic [7:0]    ETX       = 8'h03;
    localparam logic [LW-1:0] LEN_FULL  = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_MATCH = LW'(MATCH_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, DLE_SEEN} state_t;

    state_t        state_reg;
    logic          wr_bank_reg;
    logic [LW-1:0] len_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [7:0]    id_reg;
    logic [7:0]    sub_reg;
    logic [7:0]    mem [2**(AW+1)];

    logic store_req;
    logic store_ok;
    logic commit_now;
    logic time_hit;

    // A store is any payload byte: plain data in DATA, or a stuffed DLE pair.
    assign store_req  = i_rx_dv &&
                        (((state_reg == DATA) && (i_rx_byte != DLE)) ||
                         ((state_reg == DLE_SEEN) && (i_rx_byte == DLE)));
    assign store_ok   = store_req && (len_reg != LEN_FULL);
    assign commit_now = i_rx_dv && (state_reg == DLE_SEEN) && (i_rx_byte == ETX);
    assign time_hit   = commit_now && (id_reg == MATCH_ID) &&
                        (len_reg == LEN_MATCH) && (sub_reg == MATCH_SUB);
    assign o_busy     = (state_reg != IDLE);

    always_ff @(posedge i_clk) begin
        if (store_ok) begin
            mem[{wr_bank_reg, len_reg[AW-1:0]}] <= i_rx_byte;
        end
    end

    // The bank swap is registered at the ETX edge, so the o_pkt_dv cycle already reads the new bank.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else begin
            o_rd_data <= mem[{~wr_bank_reg, i_rd_addr}];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            wr_bank_reg <= 1'b0;
            len_reg     <= '0;
            tmo_cnt_reg <= '0;
            id_reg      <= '0;
            sub_reg     <= '0;
            o_pkt_dv    <= 1'b0;
            o_pkt_id    <= '0;
            o_pkt_len   <= '0;
            o_err_frame <= 1'b0;
            o_err_ovf   <= 1'b0;
            o_err_tmo   <= 1'b0;
            o_time_dv   <= 1'b0;
        end else begin
            o_pkt_dv    <= 1'b0;
            o_err_frame <= 1'b0;
            o_err_ovf   <= 1'b0;
            o_err_tmo   <= 1'b0;
            o_time_dv   <= time_hit;
            if (store_ok && (len_reg == '0)) begin
                sub_reg <= i_rx_byte;
            end
            if (store_req && !store_ok) begin
                o_err_ovf <= 1'b1;
                state_reg <= IDLE;
            end else if (store_ok) begin
                len_reg   <= len_reg + 1'b1;
                state_reg <= DATA;
            end
            if (i_rx_dv) begin
                tmo_cnt_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (i_rx_byte == DLE) state_reg <= START;
                    end
                    START: begin
                        if (i_rx_byte == ETX) begin
                            state_reg <= IDLE;
                        end else if (i_rx_byte != DLE) begin
                            id_reg    <= i_rx_byte;
                            len_reg   <= '0;
                            state_reg <= DATA;
                        end
                    end
                    DATA: begin
                        if (i_rx_byte == DLE) state_reg <= DLE_SEEN;
                    end
                    DLE_SEEN: begin
                        if (i_rx_byte == ETX) begin
                            o_pkt_dv    <= 1'b1;
                            o_pkt_id    <= id_reg;
                            o_pkt_len   <= len_reg;
                            wr_bank_reg <= ~wr_bank_reg;
                            state_reg   <= IDLE;
                        end else if (i_rx_byte != DLE) begin
                            // Resync: the offending byte becomes the ID of a fresh packet.
                            o_err_frame <= 1'b1;
                            id_reg      <= i_rx_byte;
                            len_reg     <= '0;
                            state_reg   <= DATA;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end else if (state_reg != IDLE) begin
                if (tmo_cnt_reg == TMO_LAST) begin
                    o_err_tmo   <= 1'b1;
                    tmo_cnt_reg <= '0;
                    state_reg   <= IDLE;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end
        end
    end

    // Time bytes are snooped as they are stored so the decode needs no buffer reads.
    for (genvar gi = 0; gi < 7; gi++) begin : g_time
        localparam logic [LW-1:0] IDX = LW'(SEC_IDX + gi);
        logic [7:0] cap_reg;
        logic [7:0] val_reg;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cap_reg <= '0;
                val_reg <= '0;
            end else begin
                if (store_ok && (len_reg == IDX)) cap_reg <= i_rx_byte;
                if (time_hit) val_reg <= cap_reg;
            end
        end
    end

    assign o_thunder_seconds = g_time[0].val_reg;
    assign o_thunder_minutes = g_time[1].val_reg;
    assign o_thunder_hour    = g_time[2].val_reg;
    assign o_thunder_day     = g_time[3].val_reg;
    assign o_thunder_month   = g_time[4].val_reg;
    assign o_thunder_year_h  = g_time[5].val_reg;
    assign o_thunder_year_l  = g_time[6].val_reg;
endmodule

// File: tb/tb_tsip_packet_rx.sv
// Bench for tsip_packet_rx: packets are built unstuffed, stuffed on the wire, and the
// committed results are compared with the original packet contents.
module tb_tsip_packet_rx;
    localparam int TMO = 20840;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]  id;
        logic [5:0]  len;
        logic        tdv;
        logic [55:0] t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [4:0]  rd_addr = 5'd0;
    logic [7:0]  rd_data, pkt_id;
    logic [5:0]  pkt_len;
    logic        pkt_dv, err_frame, err_ovf, err_tmo, busy, time_dv;
    logic [7:0]  yh, yl, mon, day, hr, mins, sec;
    logic [55:0] tf;

    int   checks = 0, errors = 0;
    int   n_frame = 0, n_ovf = 0, n_tmo = 0, n_multi = 0, n_orphan = 0;
    rec_t recs[$];
    rec_t mon_r;
    logic [55:0] exp_time = '0;

    tsip_packet_rx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_pkt_dv(pkt_dv), .o_pkt_id(pkt_id),
        .o_pkt_len(pkt_len), .o_err_frame(err_frame), .o_err_ovf(err_ovf),
        .o_err_tmo(err_tmo), .o_busy(busy), .o_time_dv(time_dv),
        .o_thunder_year_h(yh), .o_thunder_year_l(yl), .o_thunder_month(mon),
        .o_thunder_day(day), .o_thunder_hour(hr), .o_thunder_minutes(mins),
        .o_thunder_seconds(sec)
    );

    always #5 clk = ~clk;
    assign tf = {yl, yh, mon, day, hr, mins, sec};

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_dv) begin
                mon_r.id = pkt_id; mon_r.len = pkt_len; mon_r.tdv = time_dv; mon_r.t = tf;
                recs.push_back(mon_r);
            end
            if (time_dv && !pkt_dv) n_orphan++;
            n_frame += int'(err_frame);
            n_ovf   += int'(err_ovf);
            n_tmo   += int'(err_tmo);
            if (int'(err_frame) + int'(err_ovf) + int'(err_tmo) > 1) n_multi++;
        end
    end

    function automatic rec_t get_rec();
        rec_t r;
        r.id = 8'h00; r.len = 6'd0; r.tdv = 1'b0; r.t = '0;
        if (recs.size() != 0) r = recs.pop_front();
        return r;
    endfunction

    // Reference rule for the time decode, applied to the unstuffed packet.
    function automatic logic [55:0] model_time(input logic [7:0] id, input bq_t pl, input logic [55:0] prev);
        logic [55:0] t;
        t = prev;
        if (id == 8'h8F && pl.size() == 17 && pl[0] == 8'hAB)
            for (int k = 0; k < 7; k++) t[8*k +: 8] = pl[10 + k];
        return t;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] id, input bq_t pl, input int gapmax);
        send_byte(8'h10);
        send_byte(id);
        foreach (pl[i]) begin
            idle($urandom_range(0, gapmax));
            send_byte(pl[i]);
            if (pl[i] == 8'h10) send_byte(8'h10);
        end
        send_byte(8'h10);
        send_byte(8'h03);
        idle(2);
        $display("pkt id=%h len=%0d", id, pl.size());
    endtask

    task automatic test_reset();
        checks++; if ({pkt_dv, time_dv, err_frame, err_ovf, err_tmo, busy} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {pkt_dv, time_dv, err_frame, err_ovf, err_tmo, busy}); end
        checks++; if (pkt_id !== 8'h00) begin errors++; $display("FAIL reset_pkt_id: got %h want 00", pkt_id); end
        checks++; if (pkt_len !== 6'd0) begin errors++; $display("FAIL reset_pkt_len: got %0d want 0", pkt_len); end
        checks++; if (tf !== 56'h0) begin errors++; $display("FAIL reset_time: got %h want 0", tf); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    endtask

    task automatic test_time_pkt(input string name, input bq_t pl);
        rec_t r;
        send_pkt(8'h8F, pl, 1);
        checks++; if (recs.size() != 1) begin errors++; $display("FAIL %s_count: got %0d want 1", name, recs.size()); end
        r = get_rec();
        exp_time = model_time(8'h8F, pl, exp_time);
        checks++; if (r.id !== 8'h8F || r.len !== 6'd17) begin errors++; $display("FAIL %s_idlen: got %h/%0d want 8f/17", name, r.id, r.len); end
        checks++; if (r.tdv !== 1'b1) begin errors++; $display("FAIL %s_time_dv: got %b want 1", name, r.tdv); end
        checks++; if (r.t !== exp_time) begin errors++; $display("FAIL %s_time: got %h want %h", name, r.t, exp_time); end
        for (int k = 0; k < 17; k++) begin
            rd_addr = 5'(k); idle(1);
            checks++; if (rd_data !== pl[k]) begin errors++; $display("FAIL %s_rd[%0d]: got %h want %h", name, k, rd_data, pl[k]); end
        end
    endtask

    task automatic test_nomatch();
        rec_t r;
        bq_t pl;
        pl = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
        send_pkt(8'h8F, pl, 0);
        r = get_rec();
        checks++; if (r.id !== 8'h8F || r.len !== 6'd5) begin errors++; $display("FAIL nomatch_idlen: got %h/%0d want 8f/5", r.id, r.len); end
        checks++; if (r.tdv !== 1'b0 || n_orphan != 0) begin errors++; $display("FAIL nomatch_time_dv: got %b/%0d want 0/0", r.tdv, n_orphan); end
        checks++; if (tf !== exp_time) begin errors++; $display("FAIL nomatch_time_hold: got %h want %h", tf, exp_time); end
    endtask

    task automatic test_frame_resync();
        rec_t r;
        int f0 = n_frame;
        bq_t seq;
        seq = '{8'h10, 8'h8F, 8'hAB, 8'h10, 8'h47, 8'h01, 8'h02};
        foreach (seq[i]) send_byte(seq[i]);
        idle(2);
        checks++; if (n_frame - f0 != 1 || busy !== 1'b1) begin errors++; $display("FAIL frame_pulse: got %0d/busy %b want 1/1", n_frame - f0, busy); end
        rd_addr = 5'd0; idle(1);
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL frame_old_bank: got %h want a5", rd_data); end
        send_byte(8'h10); send_byte(8'h03); idle(2);
        checks++; if (recs.size() != 1) begin errors++; $display("FAIL frame_count: got %0d want 1", recs.size()); end
        r = get_rec();
        checks++; if (r.id !== 8'h47 || r.len !== 6'd2 || r.tdv !== 1'b0) begin errors++; $display("FAIL frame_commit: got %h/%0d/%b want 47/2/0", r.id, r.len, r.tdv); end
        rd_addr = 5'd1; idle(1);
        checks++; if (rd_data !== 8'h02) begin errors++; $display("FAIL frame_rd1: got %h want 02", rd_data); end
        $display("pkt resync id=%h len=%0d", r.id, r.len);
    endtask

    task automatic test_overflow();
        rec_t r;
        bq_t pl;
        int o0 = n_ovf;
        send_byte(8'h10); send_byte(8'h55);
        for (int i = 0; i < 32; i++) send_byte(8'(8'h20 + i));
        idle(2);
        checks++; if (n_ovf != o0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_at_32: got %0d/busy %b want 0/1", n_ovf - o0, busy); end
        send_byte(8'h40); idle(2);
        checks++; if (n_ovf - o0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL ovf_at_33: got %0d/busy %b want 1/0", n_ovf - o0, busy); end
        for (int i = 0; i < 7; i++) send_byte(8'(8'h41 + i));
        send_byte(8'h10); send_byte(8'h03); idle(2);
        checks++; if (recs.size() != 0 || n_ovf - o0 != 1) begin errors++; $display("FAIL ovf_dropped: got %0d commits/%0d ovf want 0/1", recs.size(), n_ovf - o0); end
        $display("pkt overflow id=55 dropped");
        for (int i = 0; i < 32; i++) pl.push_back(8'($urandom));
        send_pkt(8'h56, pl, 0);
        r = get_rec();
        checks++; if (r.len !== 6'd32 || n_ovf - o0 != 1) begin errors++; $display("FAIL full_len: got %0d/%0d ovf want 32/1", r.len, n_ovf - o0); end
        rd_addr = 5'd31; idle(1);
        checks++; if (rd_data !== pl[31]) begin errors++; $display("FAIL full_rd31: got %h want %h", rd_data, pl[31]); end
    endtask

    task automatic test_timeout();
        rec_t r;
        int t0 = n_tmo;
        send_byte(8'h10); send_byte(8'h66); send_byte(8'h01);
        idle(TMO);
        checks++; if (err_tmo !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b/busy %b want 1/0", err_tmo, busy); end
        idle(2);
        checks++; if (n_tmo - t0 != 1 || recs.size() != 0) begin errors++; $display("FAIL tmo_count: got %0d/%0d want 1/0", n_tmo - t0, recs.size()); end
        $display("pkt timeout id=66 dropped");
        send_byte(8'h10); send_byte(8'h66); send_byte(8'h01);
        idle(TMO - 1);
        send_byte(8'h02);
        idle(2);
        checks++; if (n_tmo - t0 != 1 || busy !== 1'b1) begin errors++; $display("FAIL tmo_edge_byte: got %0d/busy %b want 1/1", n_tmo - t0, busy); end
        send_byte(8'h10); send_byte(8'h03); idle(2);
        r = get_rec();
        checks++; if (r.id !== 8'h66 || r.len !== 6'd2) begin errors++; $display("FAIL tmo_edge_commit: got %h/%0d want 66/2", r.id, r.len); end
        $display("pkt late-byte id=%h len=%0d", r.id, r.len);
    endtask

    task automatic test_async_reset();
        rec_t r;
        bq_t pl;
        send_byte(8'h10); send_byte(8'h77); send_byte(8'h01);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({pkt_dv, time_dv, err_frame, err_ovf, err_tmo, busy} !== 6'b0 || pkt_id !== 8'h00 || pkt_len !== 6'd0) begin errors++; $display("FAIL areset_regs: got %b/%h/%0d want 0/00/0", {pkt_dv, time_dv, err_frame, err_ovf, err_tmo, busy}, pkt_id, pkt_len); end
        checks++; if (tf !== 56'h0 || rd_data !== 8'h00) begin errors++; $display("FAIL areset_time: got %h/%h want 0/00", tf, rd_data); end
        exp_time = '0;
        recs.delete();
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 9; i++) pl.push_back(8'($urandom));
        send_pkt(8'h78, pl, 1);
        r = get_rec();
        checks++; if (r.id !== 8'h78 || r.len !== 6'd9) begin errors++; $display("FAIL areset_commit: got %h/%0d want 78/9", r.id, r.len); end
        rd_addr = 5'd8; idle(1);
        checks++; if (rd_data !== pl[8]) begin errors++; $display("FAIL areset_rd8: got %h want %h", rd_data, pl[8]); end
    endtask

    task automatic test_random(input int n);
        rec_t r;
        int e0 = n_frame + n_ovf + n_tmo;
        for (int p = 0; p < n; p++) begin
            bq_t pl;
            logic [7:0] id;
            int mode = $urandom_range(0, 2);
            int len;
            id = (mode == 2) ? 8'($urandom) : 8'h8F;
            while (id == 8'h10 || id == 8'h03) id = 8'($urandom);
            len = (mode == 0) ? 17 : (mode == 1) ? (($urandom_range(0, 1) == 0) ? 16 : 18) : $urandom_range(0, 32);
            for (int i = 0; i < len; i++) pl.push_back(($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom));
            if (mode != 2 && len > 0) pl[0] = 8'hAB;
            send_pkt(id, pl, 2);
            r = get_rec();
            checks++; if (r.id !== id || r.len !== 6'(len)) begin errors++; $display("FAIL rand%0d_idlen: got %h/%0d want %h/%0d", p, r.id, r.len, id, len); end
            checks++; if (r.tdv !== (id == 8'h8F && len == 17 && pl[0] == 8'hAB)) begin errors++; $display("FAIL rand%0d_time_dv: got %b", p, r.tdv); end
            exp_time = model_time(id, pl, exp_time);
            checks++; if (r.t !== exp_time) begin errors++; $display("FAIL rand%0d_time: got %h want %h", p, r.t, exp_time); end
            for (int k = 0; k < len; k++) begin
                rd_addr = 5'(k); idle(1);
                checks++; if (rd_data !== pl[k]) begin errors++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", p, k, rd_data, pl[k]); end
            end
        end
        checks++; if (n_frame + n_ovf + n_tmo != e0 || recs.size() != 0) begin errors++; $display("FAIL rand_spurious: got %0d errors/%0d extra commits want 0/0", n_frame + n_ovf + n_tmo - e0, recs.size()); end
    endtask

    initial begin
        bq_t pl;
        idle(3);
        test_reset();
        rst_n = 1'b1;
        idle(2);
        pl = '{8'hAB, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
               8'h2A, 8'h1B, 8'h05, 8'h0C, 8'h03, 8'h07, 8'hE8};
        test_time_pkt("clean", pl);
        pl = '{8'hAB, 8'h00, 8'h10, 8'h10, 8'h05, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
               8'h10, 8'h3B, 8'h17, 8'h1F, 8'h0C, 8'h07, 8'hE9};
        test_time_pkt("stuff", pl);
        test_nomatch();
        test_frame_resync();
        test_overflow();
        test_timeout();
        test_async_reset();
        test_random(30);
        checks++; if (n_multi != 0 || n_orphan != 0) begin errors++; $display("FAIL exclusive_pulses: got %0d/%0d want 0/0", n_multi, n_orphan); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/tsip_packet_rx.md
Name: tsip_packet_rx

Overview:
- Generalised TSIP receive engine for the Thunderbolt GPS link.
- Consumes the byte stream from uart_rx (o_Rx_DV/o_Rx_Byte) and performs full DLE/ETX framing and DLE de-stuffing.
- Captures any packet into a ping-pong payload buffer and reports ID, length and errors.
- Decodes a parametrised time packet (default 8F-AB) into time-of-day fields for the pulse_generator blocks and the register map.

Parameters:
MAX_LEN, 32, payload buffer depth in bytes per bank (bytes after ID, de-stuffed, excluding DLE/ETX)
TIMEOUT_CLKS, 20840, idle clocks inside a packet before abort (2 byte times at 10 MHz/9600)
MATCH_ID, 8'h8F, packet ID that triggers time decode
MATCH_SUB, 8'hAB, required payload[0] for time decode
MATCH_LEN, 17, exact de-stuffed payload length for time decode
SEC_IDX, 10, payload index of seconds; minutes, hour, day, month, year_h, year_l follow at SEC_IDX+1..+6

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx_dv  in  1  one-cycle strobe, new byte from uart_rx
i_rx_byte  in  8  received byte
i_rd_addr  in  $clog2(MAX_LEN)  payload read address (committed bank)
o_rd_data  out  8  payload byte, registered, 1-cycle latency
o_pkt_dv  out  1  one-cycle pulse, packet committed
o_pkt_id  out  8  ID of last committed packet
o_pkt_len  out  $clog2(MAX_LEN+1)  payload length of last committed packet
o_err_frame  out  1  one-cycle pulse, DLE followed by byte other than DLE/ETX
o_err_ovf  out  1  one-cycle pulse, payload exceeded MAX_LEN
o_err_tmo  out  1  one-cycle pulse, inter-byte timeout
o_busy  out  1  high while in any state other than IDLE
o_time_dv  out  1  one-cycle pulse, time fields updated
o_thunder_year_h, o_thunder_year_l, o_thunder_month, o_thunder_day, o_thunder_hour, o_thunder_minutes, o_thunder_seconds  out  8 each  decoded time

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; write bank 0, committed bank 1; length counter 0; timeout counter 0.
- Bytes are processed only on i_rx_dv cycles. All transitions are registered.
- State machine:
  - IDLE: DLE -> START; anything else is ignored.
  - START: DLE -> stay in START; ETX -> IDLE; other byte -> latch as ID, len=0 -> DATA.
  - DATA: DLE -> DLE_SEEN; other byte -> store at write_bank[len], len++.
  - DLE_SEEN: DLE -> store 8'h10, len++ -> DATA (de-stuff). ETX -> commit -> IDLE. Other byte -> o_err_frame pulse, packet dropped, byte taken as ID of a new packet, len=0 -> DATA (resync).
- Overflow: a store attempted with len==MAX_LEN -> o_err_ovf pulse, packet dropped -> IDLE.
- Commit, the cycle after the ETX strobe:
  - o_pkt_dv=1; o_pkt_id and o_pkt_len updated; write and committed banks swap.
  - A zero-length packet (DLE id DLE ETX) is valid, with len=0.
- Time decode:
  - Condition: ID==MATCH_ID, len==MATCH_LEN and payload[0]==MATCH_SUB.
  - Effect: o_time_dv pulses in the same cycle as o_pkt_dv, and the seven time outputs load from payload[SEC_IDX..SEC_IDX+6] in that same cycle.
  - Otherwise the time outputs hold their values.
- Timeout:
  - The counter clears on every i_rx_dv and counts while state != IDLE.
  - At TIMEOUT_CLKS: o_err_tmo pulse, packet dropped -> IDLE.
  - A byte arriving in the expiry cycle wins; no timeout is raised.
- Dropped packets never swap banks and never alter o_pkt_*, the time outputs or the committed bank contents.
- Read port:
  - o_rd_data = committed_bank[i_rd_addr], registered.
  - An address sampled in the o_pkt_dv cycle already reads the new bank.
  - Addresses >= o_pkt_len return stale data (no error).
- All error pulses are mutually exclusive and are one cycle wide.

Test Plan:
- Clean 8F-AB: feed 10 8F AB + 16 payload bytes with sec=0x2A, min=0x1B, hr=0x05, day=0x0C, mon=0x03, year=0x07 0xE8 + 10 03 -> o_pkt_dv and o_time_dv together; o_pkt_len=17; o_thunder_seconds=0x2A, o_thunder_year_h=0x07, o_thunder_year_l=0xE8.
- Stuffing: time-of-week field contains 10 10 -> stored as single 0x10; o_pkt_len=17; read address 1..4 returns the de-stuffed bytes with 1-cycle latency.
- Non-matching packet: 10 8F A5 00 01 00 00 10 03 -> o_pkt_dv, o_pkt_id=0x8F, o_pkt_len=5; no o_time_dv; time outputs unchanged.
- Framing/resync: 10 8F AB 10 47 ... -> o_err_frame pulse; o_pkt_id of the next commit is 0x47; previous committed bank is still readable.
- Overflow and timeout:
  - 40 non-DLE payload bytes -> o_err_ovf on the 33rd store -> IDLE.
  - A stall of 20840 clocks mid-packet -> o_err_tmo, o_busy=0.
  - A byte on exactly clock 20840 -> no error.
- Async reset mid-packet, then a clean packet -> all outputs 0 immediately; the next packet commits normally with correct length.
